// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: opcodes, functs,
// ALU ops, mux selects, FSM states and the control word.
package multicycle_controller_pkg;

  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FN_W     = 6;
  localparam int unsigned SEL_W    = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FN_W-1:0] FN_JR  = 6'h08;
  localparam logic [FN_W-1:0] FN_ADD = 6'h20;
  localparam logic [FN_W-1:0] FN_SUB = 6'h22;
  localparam logic [FN_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'd3;

  localparam logic [SEL_W-1:0] REGDST_RT  = 2'd0;
  localparam logic [SEL_W-1:0] REGDST_RD  = 2'd1;
  localparam logic [SEL_W-1:0] REGDST_R31 = 2'd2;

  localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'd0;
  localparam logic [SEL_W-1:0] M2R_MDR    = 2'd1;
  localparam logic [SEL_W-1:0] M2R_PC     = 2'd2;

  localparam logic ALUA_PC   = 1'b0;
  localparam logic ALUA_REGA = 1'b1;

  localparam logic [SEL_W-1:0] ALUB_REGB   = 2'd0;
  localparam logic [SEL_W-1:0] ALUB_FOUR   = 2'd1;
  localparam logic [SEL_W-1:0] ALUB_IMM    = 2'd2;
  localparam logic [SEL_W-1:0] ALUB_IMM_SH = 2'd3;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'd0;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [SEL_W-1:0] PCSRC_REGA   = 2'd3;

  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_JAL       = 4'd11,
    S_JR        = 4'd12,
    S_TRAP      = 4'd13
  } state_e;

  typedef struct packed {
    logic                ir_wr;
    logic                pc_wr;
    logic                iord;
    logic                mem_rd;
    logic                mem_wr;
    logic                reg_wr;
    logic [SEL_W-1:0]    regdst;
    logic [SEL_W-1:0]    mem_to_reg;
    logic                alu_src_a;
    logic [SEL_W-1:0]    alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [SEL_W-1:0]    pc_src;
  } ctrl_t;

  // DECODE-state dispatch; anything not in the supported subset traps.
  function automatic state_e dispatch(input logic [OP_W-1:0] op, input logic [FN_W-1:0] fn);
    state_e s;
    s = S_TRAP;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_SLT: s = S_EXEC_R;
          FN_JR:                  s = S_JR;
          default:                s = S_TRAP;
        endcase
      end
      OP_LW, OP_SW:     s = S_MEM_ADDR;
      OP_ADDI, OP_XORI: s = S_EXEC_I;
      OP_BNE:           s = S_BRANCH;
      OP_J:             s = S_JUMP;
      OP_JAL:           s = S_JAL;
      default:          s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields and status in, control word out.
interface multicycle_controller_if;
  import multicycle_controller_pkg::*;

  logic [OP_W-1:0]     opcode;
  logic [FN_W-1:0]     funct;
  logic                alu_zero;
  logic                mem_ready;
  logic                ir_wr;
  logic                pc_wr;
  logic                iord;
  logic                mem_rd;
  logic                mem_wr;
  logic                reg_wr;
  logic [SEL_W-1:0]    regdst;
  logic [SEL_W-1:0]    mem_to_reg;
  logic                alu_src_a;
  logic [SEL_W-1:0]    alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [SEL_W-1:0]    pc_src;
  logic                trap;
  logic [STATE_W-1:0]  state;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output ir_wr, pc_wr, iord, mem_rd, mem_wr, reg_wr, regdst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, trap, state
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  ir_wr, pc_wr, iord, mem_rd, mem_wr, reg_wr, regdst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, trap, state
  );
endinterface

// File: rtl/multicycle_controller_decode.sv
// Combinational state -> control word lookup (Moore part of the controller).
module multicycle_controller_decode
  import multicycle_controller_pkg::*;
(
  input  state_e          state_i,
  input  logic [OP_W-1:0] opcode_i,
  input  logic [FN_W-1:0] funct_i,
  output ctrl_t           ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        // pc_wr/ir_wr are qualified by mem_ready in the top
        ctrl_o.mem_rd    = 1'b1;
        ctrl_o.iord      = IORD_PC;
        ctrl_o.ir_wr     = 1'b1;
        ctrl_o.pc_wr     = 1'b1;
        ctrl_o.alu_src_a = ALUA_PC;
        ctrl_o.alu_src_b = ALUB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a = ALUA_PC;
        ctrl_o.alu_src_b = ALUB_IMM_SH;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = ALUA_REGA;
        ctrl_o.alu_src_b = ALUB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.mem_rd = 1'b1;
        ctrl_o.iord   = IORD_ALUOUT;
      end
      S_MEM_WB: begin
        ctrl_o.reg_wr     = 1'b1;
        ctrl_o.regdst     = REGDST_RT;
        ctrl_o.mem_to_reg = M2R_MDR;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_wr = 1'b1;
        ctrl_o.iord   = IORD_ALUOUT;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = ALUA_REGA;
        ctrl_o.alu_src_b = ALUB_REGB;
        case (funct_i)
          FN_SUB:  ctrl_o.alu_op = ALU_SUB;
          FN_SLT:  ctrl_o.alu_op = ALU_SLT;
          default: ctrl_o.alu_op = ALU_ADD;
        endcase
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a = ALUA_REGA;
        ctrl_o.alu_src_b = ALUB_IMM;
        ctrl_o.alu_op    = (opcode_i == OP_XORI) ? ALU_XOR : ALU_ADD;
      end
      S_ALU_WB: begin
        ctrl_o.reg_wr     = 1'b1;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
        ctrl_o.regdst     = (opcode_i == OP_RTYPE) ? REGDST_RD : REGDST_RT;
      end
      S_BRANCH: begin
        // pc_wr is qualified by ~alu_zero in the top
        ctrl_o.alu_src_a = ALUA_REGA;
        ctrl_o.alu_src_b = ALUB_REGB;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.pc_wr     = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_src = PCSRC_JUMP;
        ctrl_o.pc_wr  = 1'b1;
      end
      S_JAL: begin
        ctrl_o.reg_wr     = 1'b1;
        ctrl_o.regdst     = REGDST_R31;
        ctrl_o.mem_to_reg = M2R_PC;
        ctrl_o.pc_src     = PCSRC_JUMP;
        ctrl_o.pc_wr      = 1'b1;
      end
      S_JR: begin
        ctrl_o.pc_src = PCSRC_REGA;
        ctrl_o.pc_wr  = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: state register, dispatch, sticky trap,
// and the mem_ready / alu_zero / reset qualification of the write enables.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  multicycle_controller_if.master   bus
);

  state_e state_q, state_d;
  logic   trap_q, trap_d;
  ctrl_t  ctrl;
  logic   pc_gate;

  multicycle_controller_decode u_decode (
    .state_i  (state_q),
    .opcode_i (bus.opcode),
    .funct_i  (bus.funct),
    .ctrl_o   (ctrl)
  );

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    state_d = dispatch(bus.opcode, bus.funct);
      S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R,
      S_EXEC_I:    state_d = S_ALU_WB;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
    trap_d = trap_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
    end
  end

  always_comb begin
    case (state_q)
      S_FETCH:  pc_gate = bus.mem_ready;
      S_BRANCH: pc_gate = ~bus.alu_zero;
      default:  pc_gate = 1'b1;
    endcase
  end

  // Writes are suppressed in a reset cycle so an aborted instruction leaves no side effect
  assign bus.ir_wr      = ctrl.ir_wr & bus.mem_ready & ~reset;
  assign bus.pc_wr      = ctrl.pc_wr & pc_gate & ~reset;
  assign bus.mem_wr     = ctrl.mem_wr & ~reset;
  assign bus.reg_wr     = ctrl.reg_wr & ~reset;
  assign bus.mem_rd     = ctrl.mem_rd;
  assign bus.iord       = ctrl.iord;
  assign bus.regdst     = ctrl.regdst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.pc_src     = ctrl.pc_src;
  assign bus.trap       = trap_q;
  assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed cycle-by-cycle bench for multicycle_controller with a per-cycle
// expected-control-word scoreboard.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [5:0] en;    // {ir_wr, pc_wr, iord, mem_rd, mem_wr, reg_wr}
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic [1:0] pcs;
    logic       tr;
  } obs_t;

  obs_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic obs_t mk(input logic [3:0] st, input logic [5:0] en,
                              input logic [1:0] rdst, input logic [1:0] m2r,
                              input logic asa, input logic [1:0] asb,
                              input logic [2:0] aop, input logic [1:0] pcs,
                              input logic tr);
    obs_t o;
    o = '{st: st, en: en, rdst: rdst, m2r: m2r, asa: asa, asb: asb,
          aop: aop, pcs: pcs, tr: tr};
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{st: bus.state,
          en: {bus.ir_wr, bus.pc_wr, bus.iord, bus.mem_rd, bus.mem_wr, bus.reg_wr},
          rdst: bus.regdst, m2r: bus.mem_to_reg, asa: bus.alu_src_a,
          asb: bus.alu_src_b, aop: bus.alu_op, pcs: bus.pc_src, tr: bus.trap};
    return o;
  endfunction

  // Expected words for the recurring fetch/decode cycles
  function automatic obs_t f_rdy();   return mk(4'd0, 6'b110100, 2'd0, 2'd0, 1'b0, 2'd1, 3'd0, 2'd0, 1'b0); endfunction
  function automatic obs_t f_stall(); return mk(4'd0, 6'b000100, 2'd0, 2'd0, 1'b0, 2'd1, 3'd0, 2'd0, 1'b0); endfunction
  function automatic obs_t dec();     return mk(4'd1, 6'b000000, 2'd0, 2'd0, 1'b0, 2'd3, 3'd0, 2'd0, 1'b0); endfunction

  task automatic step(input string tag, input logic rst, input logic mr,
                      input logic az, input obs_t e);
    obs_t got, exp_w;
    sb.push_back(e);
    reset         = rst;
    bus.mem_ready = mr;
    bus.alu_zero  = az;
    #1;
    got   = sample();
    exp_w = sb.pop_front();
    n_chk++;
    assert (got === exp_w) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp_w);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h20;
    bus.mem_ready = 1'b1;
    bus.alu_zero  = 1'b0;
    @(posedge clk);
    #1;
    step("reset", 1'b1, 1'b1, 1'b0, f_stall());

    // ADD: 0,1,6,8
    bus.opcode = 6'h00; bus.funct = 6'h20;
    step("add_fetch", 1'b0, 1'b1, 1'b0, f_rdy());
    step("add_dec",   1'b0, 1'b1, 1'b0, dec());
    step("add_exec",  1'b0, 1'b1, 1'b0, mk(4'd6, 6'b000000, 2'd0, 2'd0, 1'b1, 2'd0, 3'd0, 2'd0, 1'b0));
    step("add_wb",    1'b0, 1'b1, 1'b0, mk(4'd8, 6'b000001, 2'd1, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0));

    // SUB / SLT alu_op from funct
    bus.funct = 6'h22;
    step("sub_fetch", 1'b0, 1'b1, 1'b0, f_rdy());
    step("sub_dec",   1'b0, 1'b1, 1'b0, dec());
    step("sub_exec",  1'b0, 1'b1, 1'b0, mk(4'd6, 6'b000000, 2'd0, 2'd0, 1'b1, 2'd0, 3'd1, 2'd0, 1'b0));
    step("sub_wb",    1'b0, 1'b1, 1'b0, mk(4'd8, 6'b000001, 2'd1, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0));
    bus.funct = 6'h2A;
    step("slt_fetch", 1'b0, 1'b1, 1'b0, f_rdy());
    step("slt_dec",   1'b0, 1'b1, 1'b0, dec());
    step("slt_exec",  1'b0, 1'b1, 1'b0, mk(4'd6, 6'b000000, 2'd0, 2'd0, 1'b1, 2'd0, 3'd3, 2'd0, 1'b0));
    step("slt_wb",    1'b0, 1'b1, 1'b0, mk(4'd8, 6'b000001, 2'd1, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0));

    // ADDI / XORI: regdst=rt
    bus.opcode = 6'h08; bus.funct = 6'h3F;
    step("addi_fetch", 1'b0, 1'b1, 1'b0, f_rdy());
    step("addi_dec",   1'b0, 1'b1, 1'b0, dec());
    step("addi_exec",  1'b0, 1'b1, 1'b0, mk(4'd7, 6'b000000, 2'd0, 2'd0, 1'b1, 2'd2, 3'd0, 2'd0, 1'b0));
    step("addi_wb",    1'b0, 1'b1, 1'b0, mk(4'd8, 6'b000001, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0));
    bus.opcode = 6'h0E;
    step("xori_fetch", 1'b0, 1'b1, 1'b0, f_rdy());
    step("xori_dec",   1'b0, 1'b1, 1'b0, dec());
    step("xori_exec",  1'b0, 1'b1, 1'b0, mk(4'd7, 6'b000000, 2'd0, 2'd0, 1'b1, 2'd2, 3'd2, 2'd0, 1'b0));
    step("xori_wb",    1'b0, 1'b1, 1'b0, mk(4'd8, 6'b000001, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0));

    // LW with 2 fetch stalls and 3 read stalls: 10 cycles, one ir/pc pulse
    bus.opcode = 6'h23;
    step("lw_fstall0", 1'b0, 1'b0, 1'b0, f_stall());
    step("lw_fstall1", 1'b0, 1'b0, 1'b0, f_stall());
    step("lw_fetch",   1'b0, 1'b1, 1'b0, f_rdy());
    step("lw_dec",     1'b0, 1'b1, 1'b0, dec());
    step("lw_addr",    1'b0, 1'b1, 1'b0, mk(4'd2, 6'b000000, 2'd0, 2'd0, 1'b1, 2'd2, 3'd0, 2'd0, 1'b0));
    for (int i = 0; i < 3; i++)
      step("lw_rstall", 1'b0, 1'b0, 1'b0, mk(4'd3, 6'b001100, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0));
    step("lw_read",    1'b0, 1'b1, 1'b0, mk(4'd3, 6'b001100, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0));
    step("lw_wb",      1'b0, 1'b1, 1'b0, mk(4'd4, 6'b000001, 2'd0, 2'd1, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0));

    // BNE taken / not taken
    bus.opcode = 6'h05;
    step("bne_fetch",  1'b0, 1'b1, 1'b0, f_rdy());
    step("bne_dec",    1'b0, 1'b1, 1'b0, dec());
    step("bne_taken",  1'b0, 1'b1, 1'b0, mk(4'd9, 6'b010000, 2'd0, 2'd0, 1'b1, 2'd0, 3'd1, 2'd1, 1'b0));
    step("bne_fetch2", 1'b0, 1'b1, 1'b1, f_rdy());
    step("bne_dec2",   1'b0, 1'b1, 1'b1, dec());
    step("bne_nottkn", 1'b0, 1'b1, 1'b1, mk(4'd9, 6'b000000, 2'd0, 2'd0, 1'b1, 2'd0, 3'd1, 2'd1, 1'b0));

    // J, JAL, JR
    bus.opcode = 6'h02;
    step("j_fetch",   1'b0, 1'b1, 1'b0, f_rdy());
    step("j_dec",     1'b0, 1'b1, 1'b0, dec());
    step("j_jump",    1'b0, 1'b1, 1'b0, mk(4'd10, 6'b010000, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd2, 1'b0));
    bus.opcode = 6'h03;
    step("jal_fetch", 1'b0, 1'b1, 1'b0, f_rdy());
    step("jal_dec",   1'b0, 1'b1, 1'b0, dec());
    step("jal_jal",   1'b0, 1'b1, 1'b0, mk(4'd11, 6'b010001, 2'd2, 2'd2, 1'b0, 2'd0, 3'd0, 2'd2, 1'b0));
    bus.opcode = 6'h00; bus.funct = 6'h08;
    step("jr_fetch",  1'b0, 1'b1, 1'b0, f_rdy());
    step("jr_dec",    1'b0, 1'b1, 1'b0, dec());
    step("jr_jr",     1'b0, 1'b1, 1'b0, mk(4'd12, 6'b010000, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd3, 1'b0));

    // Illegal opcode traps and holds until reset
    bus.opcode = 6'h3F;
    step("trap_fetch", 1'b0, 1'b1, 1'b0, f_rdy());
    step("trap_dec",   1'b0, 1'b1, 1'b0, dec());
    for (int i = 0; i < 20; i++)
      step("trap_hold", 1'b0, 1'b1, 1'b0, mk(4'd13, 6'b000000, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b1));
    step("trap_rst",   1'b1, 1'b0, 1'b0, mk(4'd13, 6'b000000, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b1));
    step("trap_clr",   1'b0, 1'b0, 1'b0, f_stall());

    // SW aborted by reset while stalled in MEM_WRITE
    bus.opcode = 6'h2B;
    step("sw_fetch",  1'b0, 1'b1, 1'b0, f_rdy());
    step("sw_dec",    1'b0, 1'b1, 1'b0, dec());
    step("sw_addr",   1'b0, 1'b1, 1'b0, mk(4'd2, 6'b000000, 2'd0, 2'd0, 1'b1, 2'd2, 3'd0, 2'd0, 1'b0));
    step("sw_wstall", 1'b0, 1'b0, 1'b0, mk(4'd5, 6'b001010, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0));
    step("sw_rst",    1'b1, 1'b0, 1'b0, mk(4'd5, 6'b001000, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0));
    step("sw_abort",  1'b0, 1'b0, 1'b0, f_stall());

    // SW completes normally: 4 cycles
    step("sw2_fetch", 1'b0, 1'b1, 1'b0, f_rdy());
    step("sw2_dec",   1'b0, 1'b1, 1'b0, dec());
    step("sw2_addr",  1'b0, 1'b1, 1'b0, mk(4'd2, 6'b000000, 2'd0, 2'd0, 1'b1, 2'd2, 3'd0, 2'd0, 1'b0));
    step("sw2_write", 1'b0, 1'b1, 1'b0, mk(4'd5, 6'b001010, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0));
    step("sw2_next",  1'b0, 1'b0, 1'b0, f_stall());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
